aes128_key_schedule_ctrl: RTL and testbench
===========================================

Name: aes128_key_schedule_ctrl

Overview:
- Sequencer for the full AES-128 key schedule.
- Accepts a 128-bit cipher key over a valid/ready handshake and iterates the single-round key transform 10 times, one round per clock.
- Stores round keys 0..10 in an internal 11-entry register file.
- Downstream, the round datapath (encrypt or decrypt) reads any round key by index, so decryption can walk keys in reverse order.

Parameters:
- NUM_ROUNDS, 10, number of expansion rounds; only 10 (AES-128) is supported, any other value is a configuration error.

Ports:
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- key_valid  in  1  cipher key present on key_in
- key_ready  out  1  block can accept a new key
- key_in  in  128  cipher key; byte 0 = key_in[127:120], word w0 = key_in[127:96]
- rd_idx  in  4  round key index to read (0..10)
- rd_key  out  128  registered round key for rd_idx
- rd_valid  out  1  rd_key holds a key already expanded from the current cipher key
- keys_valid  out  1  all 11 round keys for the current key are available
- busy  out  1  expansion in progress

Behaviour:
- Reset (async, reset_n low):
  - state=IDLE; all 11 slots = 0; working key = 0; rc = 8'h01; round counter = 0.
  - Outputs: key_ready=1, keys_valid=0, busy=0, rd_key=0, rd_valid=0.
- States: IDLE, EXPAND, DONE.
  - key_ready = 1 in IDLE and DONE, 0 in EXPAND.
  - busy = 1 only in EXPAND.
- Accept: handshake occurs at the edge where key_valid & key_ready = 1 (call it edge N).
  - At edge N: slot0 <= key_in; working <= key_in; rc <= 8'h01; cnt <= 1; keys_valid <= 0; state <= EXPAND.
- Round transform (combinational from working key W = {w0,w1,w2,w3}):
  - g = {S(w3[23:16]), S(w3[15:8]), S(w3[7:0]), S(w3[31:24])} ^ {rc, 24'h0}, using the existing SBox module (addr/dout, combinational), 4 instances.
  - n0 = w0^g; n1 = w1^n0; n2 = w2^n1; n3 = w3^n2; next = {n0,n1,n2,n3}.
- EXPAND, each edge:
  - slot[cnt] <= next; working <= next; cnt <= cnt+1.
  - rc <= xtime(rc): (rc<<1) ^ (rc[7] ? 8'h1B : 8'h00), giving 01,02,04,08,10,20,40,80,1B,36.
  - When cnt==10 the write happens and state <= DONE, keys_valid <= 1.
- Latency: slot k is written at edge N+k (k = 1..10). keys_valid=1 and key_ready=1 are visible after edge N+10. Throughput is one key per 11 cycles.
- DONE: holds all slots; keys_valid stays 1. A new handshake restarts exactly as from IDLE; keys_valid falls after the accepting edge.
- key_valid during EXPAND: ignored, no handshake (key_ready=0); key_in not sampled.
- Read port, registered, 1-cycle latency:
  - At each edge: rd_key <= slot[rd_idx]; rd_valid <= (rd_idx <= 10) & (rd_idx < written_count).
  - written_count = 0 in IDLE after reset, cnt during EXPAND, 11 in DONE.
  - rd_idx 11..15: rd_key <= 0, rd_valid <= 0.
- Same-edge read/write of a slot: read returns the old slot content with rd_valid=0. No bypass.
- Reset mid-EXPAND: immediate return to reset state; partial keys are discarded (slots cleared).

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c accepted at edge N:
  - slot1 = a0fafe1788542cb123a339392a6c7605
  - slot10 = d014f9a8c9ee2589e13f0cc8b6630ca6
  - keys_valid rises after edge N+10.
- All-zero key:
  - slot1 = 62636363626363636263636362636363
  - slot10 = b4ef5bcb3e92e21123e951cf6f8f188e
- key_valid held high through EXPAND with a different key_in -> ignored; key_ready=0 for 10 cycles; results match the first key only.
- Reads during EXPAND:
  - rd_idx=3 at cycle N+2 -> rd_valid=0.
  - rd_idx=3 at cycle N+4 -> rd_valid=1 with the correct key.
  - rd_idx=12 -> rd_key=0, rd_valid=0.
- Back-to-back keys:
  - Second key accepted in the first DONE cycle -> keys_valid drops, then rises again 10 edges later with the second key's schedule.
- reset_n pulsed low at cycle N+5 -> all outputs return to reset values asynchronously; the next accepted key expands correctly.

Source files
------------

// File: rtl/aes128_key_schedule_ctrl.sv
// AES-128 key schedule sequencer: accepts a cipher key, expands one round key per clock
// into an 11-entry slot file, and serves any round key by index with one cycle of latency.

module aes_sbox (
  input  logic [7:0] addr,
  output logic [7:0] dout
);

  // Entry 0 sits in the top byte, so entry k lives at bit offset (255-k)*8 = {~k, 3'b000}.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] bit_idx;

  assign bit_idx = {~addr, 3'b000};
  assign dout    = SBOX_TABLE[bit_idx +: 8];

endmodule

module aes128_key_schedule_ctrl #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key_in,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key,
  output logic         rd_valid,
  output logic         keys_valid,
  output logic         busy
);

  generate
    if (NUM_ROUNDS != 10) begin : g_cfg_err
      $error("aes128_key_schedule_ctrl: only NUM_ROUNDS=10 (AES-128) is supported");
    end
  endgenerate

  localparam logic [3:0] LAST_CNT  = 4'd10;
  localparam logic [3:0] NUM_SLOTS = 4'd11;

  // state  | meaning
  // IDLE   | no key accepted since reset; ready for a key
  // EXPAND | producing one round key per clock, key_ready low
  // DONE   | all 11 round keys held; ready for the next key
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic         accept;
  logic         last_round;
  logic [3:0]   wr_count;

  logic [127:0] slot_q [0:10];
  logic [127:0] working_q;
  logic [7:0]   rc_q;
  logic [3:0]   cnt_q;
  logic         keys_valid_q;
  logic [127:0] rd_key_q;
  logic         rd_valid_q;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  sub_rot;
  logic [31:0]  g_word;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] next_key;
  logic [7:0]   rc_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    key_ready  = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    last_round = 1'b0;
    wr_count   = 4'd0;
    case (state_q)
      IDLE: begin
        key_ready = 1'b1;
        accept    = key_valid;
        if (key_valid) state_d = EXPAND;
      end
      EXPAND: begin
        busy     = 1'b1;
        wr_count = cnt_q;
        if (cnt_q == LAST_CNT) begin
          last_round = 1'b1;
          state_d    = DONE;
        end
      end
      DONE: begin
        key_ready = 1'b1;
        wr_count  = NUM_SLOTS;
        accept    = key_valid;
        if (key_valid) state_d = EXPAND;
      end
      default: state_d = IDLE;
    endcase
  end

  assign {w0, w1, w2, w3} = working_q;

  // RotWord is folded into the S-box wiring: byte order {w3[23:16], w3[15:8], w3[7:0], w3[31:24]}.
  aes_sbox u_sbox0 (.addr(w3[23:16]), .dout(sub_rot[31:24]));
  aes_sbox u_sbox1 (.addr(w3[15:8]),  .dout(sub_rot[23:16]));
  aes_sbox u_sbox2 (.addr(w3[7:0]),   .dout(sub_rot[15:8]));
  aes_sbox u_sbox3 (.addr(w3[31:24]), .dout(sub_rot[7:0]));

  assign g_word   = sub_rot ^ {rc_q, 24'h000000};
  assign n0       = w0 ^ g_word;
  assign n1       = w1 ^ n0;
  assign n2       = w2 ^ n1;
  assign n3       = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};
  assign rc_next  = {rc_q[6:0], 1'b0} ^ (rc_q[7] ? 8'h1b : 8'h00);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 11; i++) begin
        slot_q[i] <= '0;
      end
      working_q    <= '0;
      rc_q         <= 8'h01;
      cnt_q        <= 4'd0;
      keys_valid_q <= 1'b0;
      rd_key_q     <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      if (accept) begin
        slot_q[0]    <= key_in;
        working_q    <= key_in;
        rc_q         <= 8'h01;
        cnt_q        <= 4'd1;
        keys_valid_q <= 1'b0;
      end else if (busy) begin
        slot_q[cnt_q] <= next_key;
        working_q     <= next_key;
        rc_q          <= rc_next;
        cnt_q         <= cnt_q + 4'd1;
        if (last_round) keys_valid_q <= 1'b1;
      end

      // Reads see the pre-edge slot contents; a slot written on this edge reads as not valid.
      if (rd_idx <= LAST_CNT) begin
        rd_key_q <= slot_q[rd_idx];
      end else begin
        rd_key_q <= '0;
      end
      rd_valid_q <= (rd_idx <= LAST_CNT) && (rd_idx < wr_count);
    end
  end

  assign rd_key     = rd_key_q;
  assign rd_valid   = rd_valid_q;
  assign keys_valid = keys_valid_q;

endmodule

// File: tb/tb_aes128_key_schedule_ctrl.sv
// Bench for aes128_key_schedule_ctrl: vector table plus random keys against a word-level
// FIPS-197 key expansion model with a GF(2^8)-computed S-box, and multi-cycle corner sequences.

module tb_aes128_key_schedule_ctrl;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key_in;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;
  logic         rd_valid;
  logic         keys_valid;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]   sbox_m [256];
  logic [127:0] exp_keys [11];

  typedef struct {
    logic [127:0] key;
    logic [127:0] s1;
    logic [127:0] s10;
  } vec_t;

  vec_t vecs [5];

  aes128_key_schedule_ctrl #(.NUM_ROUNDS(10)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key_in     (key_in),
    .rd_idx     (rd_idx),
    .rd_key     (rd_key),
    .rd_valid   (rd_valid),
    .keys_valid (keys_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int v = 0; v < 256; v++) begin
      inv = 8'h00;
      for (int x = 1; x < 256; x++) begin
        if (gmul(8'(v), 8'(x)) == 8'h01) inv = 8'(x);
      end
      sbox_m[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    rcon = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
        t = t ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Leaves the bench at the negedge after the accepting edge N.
  task automatic accept_key(input logic [127:0] k, input bit hold);
    chk("key_ready_before_accept", key_ready, 1);
    key_valid = 1'b1;
    key_in    = k;
    tick();
    if (!hold) key_valid = 1'b0;
    model_expand(k);
    chk("keys_valid_after_accept", keys_valid, 0);
    chk("busy_after_accept", busy, 1);
    chk("key_ready_after_accept", key_ready, 0);
  endtask

  task automatic wait_done(input string name);
    int e;
    e = 0;
    while (e < 20) begin
      tick();
      e++;
      if (keys_valid) break;
      chk({name, "_busy"}, busy, 1);
      chk({name, "_key_ready_low"}, key_ready, 0);
    end
    key_valid = 1'b0;
    chk({name, "_latency"}, 128'(e), 128'd10);
    chk({name, "_busy_done"}, busy, 0);
    chk({name, "_key_ready_done"}, key_ready, 1);
  endtask

  task automatic check_all(input string name);
    for (int idx = 0; idx < 16; idx++) begin
      rd_idx = 4'(idx);
      tick();
      chk($sformatf("%s_rd_key_%0d", name, idx), rd_key, (idx <= 10) ? exp_keys[idx] : 128'h0);
      chk($sformatf("%s_rd_valid_%0d", name, idx), rd_valid, (idx <= 10) ? 1 : 0);
    end
  endtask

  task automatic read_one(input logic [3:0] idx, output logic [127:0] k, output logic v);
    rd_idx = idx;
    tick();
    k = rd_key;
    v = rd_valid;
  endtask

  initial begin
    logic [127:0] k;
    logic         v;

    reset_n   = 1'b0;
    key_valid = 1'b0;
    key_in    = '0;
    rd_idx    = 4'd0;
    build_sbox();

    vecs[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'ha0fafe1788542cb123a339392a6c7605,
                128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[1] = '{128'h0,
                128'h62636363626363636263636362636363,
                128'hb4ef5bcb3e92e21123e951cf6f8f188e};
    for (int i = 2; i < 5; i++) begin
      vecs[i].key = {$urandom, $urandom, $urandom, $urandom};
      model_expand(vecs[i].key);
      vecs[i].s1  = exp_keys[1];
      vecs[i].s10 = exp_keys[10];
    end

    repeat (3) @(negedge clk);
    chk("rst_key_ready", key_ready, 1);
    chk("rst_keys_valid", keys_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_key", rd_key, 0);
    chk("rst_rd_valid", rd_valid, 0);
    reset_n = 1'b1;
    tick();
    chk("idle_rd_valid", rd_valid, 0);
    chk("idle_rd_key", rd_key, 0);

    for (int i = 0; i < 5; i++) begin
      accept_key(vecs[i].key, 1'b0);
      wait_done($sformatf("vec%0d", i));
      read_one(4'd1, k, v);
      chk($sformatf("vec%0d_slot1", i), k, vecs[i].s1);
      read_one(4'd10, k, v);
      chk($sformatf("vec%0d_slot10", i), k, vecs[i].s10);
      check_all($sformatf("vec%0d", i));
    end

    // key_valid held through EXPAND with a different key_in must be ignored.
    accept_key(vecs[0].key, 1'b1);
    key_in = vecs[1].key;
    wait_done("hold");
    check_all("hold");

    // Reads during EXPAND: slot 3 becomes readable from the edge where cnt is 4.
    accept_key(vecs[2].key, 1'b0);
    rd_idx = 4'd3;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (e == 7) begin
        chk("exp_rd12_key", rd_key, 0);
        chk("exp_rd12_valid", rd_valid, 0);
        rd_idx = 4'd3;
      end else begin
        chk($sformatf("exp_rd3_valid_e%0d", e), rd_valid, (e >= 4) ? 1 : 0);
        if (e >= 4) chk($sformatf("exp_rd3_key_e%0d", e), rd_key, exp_keys[3]);
      end
      if (e == 6) rd_idx = 4'd12;
      if (e < 10) chk($sformatf("exp_keys_valid_e%0d", e), keys_valid, 0);
    end
    chk("exp_keys_valid_final", keys_valid, 1);

    // Back-to-back: second key accepted in the first DONE cycle.
    accept_key(vecs[3].key, 1'b0);
    wait_done("b2b_first");
    accept_key(vecs[4].key, 1'b0);
    wait_done("b2b_second");
    check_all("b2b");

    // Async reset mid-EXPAND discards partial keys.
    accept_key(vecs[0].key, 1'b0);
    rd_idx = 4'd1;
    repeat (5) tick();
    chk("mid_rd_valid_pre_reset", rd_valid, 1);
    chk("mid_rd_key_pre_reset", rd_key, vecs[0].s1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_key_ready", key_ready, 1);
    chk("mid_rst_keys_valid", keys_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rd_key", rd_key, 0);
    chk("mid_rst_rd_valid", rd_valid, 0);
    @(negedge clk);
    reset_n = 1'b1;
    read_one(4'd1, k, v);
    chk("post_rst_slot1_cleared", k, 0);
    chk("post_rst_slot1_valid", v, 0);
    read_one(4'd0, k, v);
    chk("post_rst_slot0_cleared", k, 0);
    accept_key(vecs[1].key, 1'b0);
    wait_done("post_rst");
    check_all("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
